// File: rtl/shift_multi_read_line.sv
// rtl/shift_multi_read_line.sv - DEPTH-stage word shift line with window taps, oldest-word output and optional random read
//
// Purpose:
//    Shifts one WIDTH-bit word into stage 0 on every enabled clock edge.
//    Older words move one stage deeper, and the word in the last stage is dropped.
//    Stages 2..7 are exposed as window taps. The last stage drives rd_data so
//    instances can be chained. There is no full/empty flag and no backpressure.
//
// Optional feature (macro SHIFT_ADDR_READ_EN):
//    defined   - addr_data = stage[addr] for addr < DEPTH, zero otherwise (no wrap)
//    undefined - addr_data is tied to zero, addr is ignored, no read mux is built
//
// Ports:
//    clk       in   1      single clock, rising edge
//    rst       in   1      synchronous active-high reset, clears every stage, wins over write_en
//    write_en  in   1      shift enable, one word accepted per enabled edge
//    addr      in   7      random-read stage index
//    wr_data   in   WIDTH  word shifted into stage 0
//    rd_data   out  WIDTH  stage DEPTH-1 (oldest word)
//    p2..p7    out  WIDTH  stages 2..7
//    addr_data out  WIDTH  stage addr (see optional feature)

module shift_multi_read_line #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             write_en,
   input  logic [6:0]       addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] p2,
   output logic [WIDTH-1:0] p3,
   output logic [WIDTH-1:0] p4,
   output logic [WIDTH-1:0] p5,
   output logic [WIDTH-1:0] p6,
   output logic [WIDTH-1:0] p7,
   output logic [WIDTH-1:0] addr_data
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else if (write_en) begin
         r_stage[0] <= wr_data;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign rd_data = r_stage[DEPTH-1];
   assign p2      = r_stage[2];
   assign p3      = r_stage[3];
   assign p4      = r_stage[4];
   assign p5      = r_stage[5];
   assign p6      = r_stage[6];
   assign p7      = r_stage[7];

`ifdef SHIFT_ADDR_READ_EN
   localparam int AW = $clog2(DEPTH);

   logic          w_in_range;
   logic [AW-1:0] w_idx;

   // Out-of-range addresses read zero rather than aliasing onto a low stage.
   assign w_in_range = (32'(addr) < DEPTH);
   assign w_idx      = addr[AW-1:0];
   assign addr_data  = w_in_range ? r_stage[w_idx] : '0;
`else
   logic w_unused_addr;

   assign w_unused_addr = ^addr;
   assign addr_data     = '0;
`endif

endmodule

// File: tb/tb_shift_multi_read_line.sv
// tb/tb_shift_multi_read_line.sv - self-checking bench: 8-stage line chained into a 32-stage line
module tb_shift_multi_read_line;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        write_en = 1'b0;
   logic [6:0]  addr = 7'd0;
   logic [31:0] wr_data = 32'd0;

   logic [31:0] a_rd, a_p2, a_p3, a_p4, a_p5, a_p6, a_p7, a_ad;
   logic [31:0] b_rd, b_p2, b_p3, b_p4, b_p5, b_p6, b_p7, b_ad;
   logic [31:0] a_tap [2:7];

   int checks = 0;
   int failures = 0;

   // Reference: most recent word first. Stage i of the chained 40-word line is hist[i].
   logic [31:0] hist [$];

   always #5 clk = ~clk;

   shift_multi_read_line #(.WIDTH(32), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .write_en(write_en), .addr(addr), .wr_data(wr_data),
      .rd_data(a_rd), .p2(a_p2), .p3(a_p3), .p4(a_p4), .p5(a_p5), .p6(a_p6), .p7(a_p7),
      .addr_data(a_ad)
   );

   shift_multi_read_line #(.WIDTH(32), .DEPTH(32)) dut_b (
      .clk(clk), .rst(rst), .write_en(write_en), .addr(addr), .wr_data(a_rd),
      .rd_data(b_rd), .p2(b_p2), .p3(b_p3), .p4(b_p4), .p5(b_p5), .p6(b_p6), .p7(b_p7),
      .addr_data(b_ad)
   );

   assign a_tap[2] = a_p2;
   assign a_tap[3] = a_p3;
   assign a_tap[4] = a_p4;
   assign a_tap[5] = a_p5;
   assign a_tap[6] = a_p6;
   assign a_tap[7] = a_p7;

   function automatic logic [31:0] m_stage(int i);
      return (i < hist.size()) ? hist[i] : 32'd0;
   endfunction

   function automatic logic [31:0] m_addr(logic [6:0] a);
`ifdef SHIFT_ADDR_READ_EN
      return (a < 7'd8) ? m_stage(int'(a)) : 32'd0;
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick(input logic r, input logic we, input logic [31:0] d);
      rst = r;
      write_en = we;
      wr_data = d;
      @(posedge clk);
      if (r) begin
         hist.delete();
      end else if (we) begin
         hist.push_front(d);
         if (hist.size() > 40) void'(hist.pop_back());
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, $urandom | 32'h1);
      tick(1'b1, 1'b1, 32'hFFFF_FFFF);
      tick(1'b0, 1'b0, 32'h1234_5678);
      checks++;
      if (a_rd !== 32'd0) begin
         failures++;
         $display("FAIL reset_rd_data got=%h exp=%h", a_rd, 32'd0);
      end
      for (int k = 2; k <= 7; k++) begin
         checks++;
         if (a_tap[k] !== 32'd0) begin
            failures++;
            $display("FAIL reset_p%0d got=%h exp=%h", k, a_tap[k], 32'd0);
         end
      end
      for (int a = 0; a < 10; a++) begin
         addr = 7'(a);
         #1;
         checks++;
         if (a_ad !== 32'd0) begin
            failures++;
            $display("FAIL reset_addr_data addr=%0d got=%h exp=%h", a, a_ad, 32'd0);
         end
      end
      checks++;
      if (b_rd !== 32'd0) begin
         failures++;
         $display("FAIL reset_chain_rd got=%h exp=%h", b_rd, 32'd0);
      end
   endtask

   task automatic test_latency();
      tick(1'b1, 1'b0, 32'd0);
      for (int i = 1; i <= 8; i++) tick(1'b0, 1'b1, 32'(i));
      checks++;
      if (a_rd !== 32'd1) begin
         failures++;
         $display("FAIL latency_rd_8 got=%h exp=%h", a_rd, 32'd1);
      end
      checks++;
      if (a_p2 !== 32'd6) begin
         failures++;
         $display("FAIL latency_p2_8 got=%h exp=%h", a_p2, 32'd6);
      end
      checks++;
      if (a_p7 !== 32'd1) begin
         failures++;
         $display("FAIL latency_p7_8 got=%h exp=%h", a_p7, 32'd1);
      end
      tick(1'b0, 1'b1, 32'd9);
      checks++;
      if (a_rd !== 32'd2) begin
         failures++;
         $display("FAIL latency_rd_9 got=%h exp=%h", a_rd, 32'd2);
      end
   endtask

   task automatic test_hold();
      tick(1'b1, 1'b0, 32'd0);
      for (int i = 1; i <= 8; i++) tick(1'b0, 1'b1, 32'(i));
      for (int e = 0; e < 5; e++) begin
         tick(1'b0, 1'b0, 32'hDEAD);
         // After filling 1..8 the taps read stage k = 8-k.
         for (int k = 2; k <= 7; k++) begin
            checks++;
            if (a_tap[k] !== 32'(8 - k)) begin
               failures++;
               $display("FAIL hold_p%0d edge=%0d got=%h exp=%h", k, e, a_tap[k], 32'(8 - k));
            end
         end
         checks++;
         if (a_rd !== 32'd1) begin
            failures++;
            $display("FAIL hold_rd edge=%0d got=%h exp=%h", e, a_rd, 32'd1);
         end
      end
      tick(1'b0, 1'b1, 32'hDEAD);
      addr = 7'd0;
      #1;
      checks++;
      if (a_rd !== 32'd2 || a_p2 !== 32'd7) begin
         failures++;
         $display("FAIL hold_release got rd=%h p2=%h exp rd=%h p2=%h", a_rd, a_p2, 32'd2, 32'd7);
      end
      checks++;
      if (a_ad !== m_addr(7'd0)) begin
         failures++;
         $display("FAIL hold_release_stage0 got=%h exp=%h", a_ad, m_addr(7'd0));
      end
   endtask

   task automatic test_addr_read();
      logic [6:0]  pts [4];
      logic [31:0] want [4];
      tick(1'b1, 1'b0, 32'd0);
      for (int i = 1; i <= 8; i++) tick(1'b0, 1'b1, 32'(i));
      pts[0] = 7'd0;   pts[1] = 7'd7;   pts[2] = 7'd8;   pts[3] = 7'd127;
`ifdef SHIFT_ADDR_READ_EN
      want[0] = 32'd8; want[1] = 32'd1; want[2] = 32'd0; want[3] = 32'd0;
`else
      want[0] = 32'd0; want[1] = 32'd0; want[2] = 32'd0; want[3] = 32'd0;
`endif
      for (int j = 0; j < 4; j++) begin
         addr = pts[j];
         #1;
         checks++;
         if (a_ad !== want[j]) begin
            failures++;
            $display("FAIL addr_read addr=%0d got=%h exp=%h", pts[j], a_ad, want[j]);
         end
      end
      for (int j = 0; j < 16; j++) begin
         addr = 7'($urandom_range(0, 127));
         #1;
         checks++;
         if (a_ad !== m_addr(addr)) begin
            failures++;
            $display("FAIL addr_read_rand addr=%0d got=%h exp=%h", addr, a_ad, m_addr(addr));
         end
      end
   endtask

   task automatic test_chain();
      int          edges;
      bit          seen;
      logic [31:0] d;
      logic        we;
      tick(1'b1, 1'b0, 32'd0);
      edges = 0;
      seen = 1'b0;
      d = 32'd1;
      for (int c = 0; c < 200 && !seen; c++) begin
         we = ($urandom_range(0, 3) != 0);
         tick(1'b0, we, we ? d : 32'hFFFF_0001);
         if (we) begin
            edges++;
            d++;
         end
         if (b_rd == 32'd1) seen = 1'b1;
      end
      checks++;
      if (!seen || edges != 40) begin
         failures++;
         $display("FAIL chain_latency seen=%0d edges=%0d exp_edges=%0d", seen, edges, 40);
      end
   endtask

   task automatic test_reset_priority();
      tick(1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, $urandom | 32'h1);
      tick(1'b1, 1'b1, 32'hCAFE_F00D);
      for (int k = 2; k <= 7; k++) begin
         checks++;
         if (a_tap[k] !== 32'd0) begin
            failures++;
            $display("FAIL rstpri_p%0d got=%h exp=%h", k, a_tap[k], 32'd0);
         end
      end
      tick(1'b0, 1'b1, 32'h0BAD_BEEF);
      for (int a = 0; a < 8; a++) begin
         addr = 7'(a);
         #1;
         checks++;
         if (a_ad !== m_addr(7'(a))) begin
            failures++;
            $display("FAIL rstpri_after addr=%0d got=%h exp=%h", a, a_ad, m_addr(7'(a)));
         end
      end
      checks++;
      if (a_rd !== 32'd0 || a_p2 !== 32'd0) begin
         failures++;
         $display("FAIL rstpri_after_taps got rd=%h p2=%h exp=%h", a_rd, a_p2, 32'd0);
      end
   endtask

   task automatic test_random();
      logic r;
      logic we;
      for (int c = 0; c < 400; c++) begin
         r  = ($urandom_range(0, 49) == 0);
         we = ($urandom_range(0, 2) != 0);
         tick(r, we, $urandom);
         addr = 7'($urandom_range(0, 15));
         #1;
         checks++;
         if (a_rd !== m_stage(7) || a_p2 !== m_stage(2) || a_p3 !== m_stage(3) ||
             a_p4 !== m_stage(4) || a_p5 !== m_stage(5) || a_p6 !== m_stage(6) ||
             a_p7 !== m_stage(7) || a_ad !== m_addr(addr)) begin
            failures++;
            $display("FAIL random_a cyc=%0d rd=%h p2=%h ad=%h exp rd=%h p2=%h ad=%h",
                     c, a_rd, a_p2, a_ad, m_stage(7), m_stage(2), m_addr(addr));
         end
         checks++;
         if (b_rd !== m_stage(39) || b_p2 !== m_stage(10) || b_p7 !== m_stage(15)) begin
            failures++;
            $display("FAIL random_b cyc=%0d rd=%h p2=%h p7=%h exp rd=%h p2=%h p7=%h",
                     c, b_rd, b_p2, b_p7, m_stage(39), m_stage(10), m_stage(15));
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_latency();
      test_hold();
      test_addr_read();
      test_chain();
      test_reset_priority();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
